// File: rtl/sram_burst_ctrl.sv
// Burst read/write controller for the single-port synchronous SRAM.
// Read data returns through a 2-entry FIFO so the client can stall indefinitely.
module sram_burst_ctrl #(
  parameter int ADR  = 16,
  parameter int BITS = 32,
  parameter int LEN  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_wr,
  input  logic [ADR-1:0]  cmd_adr,
  input  logic [LEN-1:0]  cmd_len,
  input  logic            wd_valid,
  output logic            wd_ready,
  input  logic [BITS-1:0] wd_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [BITS-1:0] rd_data,
  output logic            busy,
  output logic [ADR-1:0]  mem_adr,
  output logic [BITS-1:0] mem_in,
  output logic            mem_we,
  output logic            mem_oe,
  input  logic [BITS-1:0] mem_out
);

  // state   | meaning
  // S_IDLE  | waiting for a command
  // S_WRITE | accepting write beats, one SRAM write per beat
  // S_READ  | issuing SRAM reads while FIFO + in-flight <= 2
  // S_DRAIN | all reads issued, waiting for the FIFO to empty
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [ADR-1:0]  r_cur_adr;
  logic [LEN-1:0]  r_beats_left;
  logic            r_oe_q;
  logic [BITS-1:0] r_fifo [2];
  logic            r_rd_ptr;
  logic [1:0]      r_cnt;

  logic            w_push;
  logic            w_pop;
  logic [2:0]      w_occ;
  logic            w_issue;
  logic            w_wr_beat;
  logic            w_last;

  assign w_push    = r_oe_q;
  assign w_pop     = (r_cnt != 2'd0) && rd_ready;
  // Occupancy after this cycle's pop; issuing only while <= 1 caps outstanding words at 2.
  assign w_occ     = {1'b0, r_cnt} + {2'b00, r_oe_q} - {2'b00, w_pop};
  assign w_issue   = (r_state == S_READ) && (w_occ <= 3'd1);
  assign w_wr_beat = (r_state == S_WRITE) && wd_valid;
  assign w_last    = (r_beats_left == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid) w_next = cmd_wr ? S_WRITE : S_READ;
      S_WRITE: if (wd_valid && w_last) w_next = S_IDLE;
      S_READ:  if (w_issue && w_last) w_next = S_DRAIN;
      S_DRAIN: if ((r_cnt == 2'd0) && !r_oe_q) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (r_state == S_IDLE);
    wd_ready  = (r_state == S_WRITE);
    busy      = (r_state != S_IDLE);
    mem_we    = w_wr_beat;
    mem_oe    = w_issue;
    mem_in    = '0;
    if (r_state == S_WRITE) mem_in = wd_data;
    rd_valid  = (r_cnt != 2'd0);
    rd_data   = '0;
    if (r_cnt != 2'd0) rd_data = r_fifo[r_rd_ptr];
  end

  assign mem_adr = r_cur_adr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_adr    <= '0;
      r_beats_left <= '0;
      r_oe_q       <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_cnt        <= 2'd0;
      for (int i = 0; i < 2; i++) r_fifo[i] <= '0;
    end else begin
      r_oe_q <= w_issue;
      if ((r_state == S_IDLE) && cmd_valid) begin
        r_cur_adr    <= cmd_adr;
        r_beats_left <= cmd_len;
      end else if (w_wr_beat || w_issue) begin
        r_cur_adr    <= r_cur_adr + 1'b1;
        r_beats_left <= r_beats_left - 1'b1;
      end
      if (w_push) r_fifo[r_rd_ptr ^ r_cnt[0]] <= mem_out;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Bench for sram_burst_ctrl: SRAM model plus a flat expected-memory reference,
// directed bursts followed by randomized write/read-back bursts.
module tb_sram_burst_ctrl;
  localparam int ADR  = 16;
  localparam int BITS = 32;
  localparam int LEN  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid, cmd_ready, cmd_wr;
  logic [ADR-1:0]  cmd_adr;
  logic [LEN-1:0]  cmd_len;
  logic            wd_valid, wd_ready;
  logic [BITS-1:0] wd_data;
  logic            rd_valid, rd_ready;
  logic [BITS-1:0] rd_data;
  logic            busy;
  logic [ADR-1:0]  mem_adr;
  logic [BITS-1:0] mem_in;
  logic            mem_we, mem_oe;
  logic [BITS-1:0] mem_out;

  logic [BITS-1:0] sram    [0:65535];
  logic [BITS-1:0] exp_mem [0:65535];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int outst = 0;

  always #5 clk = ~clk;

  sram_burst_ctrl #(.ADR(ADR), .BITS(BITS), .LEN(LEN)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy),
    .mem_adr(mem_adr), .mem_in(mem_in), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_out(mem_out)
  );

  // Single-port SRAM with one-cycle registered read
  always @(posedge clk) begin
    if (mem_we) sram[mem_adr] <= mem_in;
    if (mem_oe) mem_out <= sram[mem_adr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    #1;
    chk("we_oe_exclusive", 64'(mem_we & mem_oe), 64'd0);
    outst = outst + int'(mem_oe) - int'(rd_valid & rd_ready);
    chk("outstanding_le_2", 64'(outst <= 2), 64'd1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_write(input logic [15:0] adr, input int len, input logic [31:0] pat,
                          input bit rnd, input string tag);
    logic [31:0] d;
    logic        wv;
    int          i, g;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_adr = adr; cmd_len = 8'(len);
    #1;
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0;
    i = 0; g = 0;
    while (i <= len && g < 200) begin
      wv = rnd ? 1'($urandom_range(0, 1)) : pat[g % 32];
      d  = $urandom;
      wd_valid = wv; wd_data = d;
      #1;
      chk({tag, "_wd_ready"}, 64'(wd_ready), 64'd1);
      chk({tag, "_mem_we"}, 64'(mem_we), 64'(wv));
      if (wv) begin
        chk({tag, "_mem_adr"}, 64'(mem_adr), 64'(16'(adr + 16'(i))));
        chk({tag, "_mem_in"}, 64'(mem_in), 64'(d));
        exp_mem[16'(adr + 16'(i))] = d;
        i++;
      end
      step();
      g++;
    end
    wd_valid = 1'b0;
    #1;
    chk({tag, "_beats_done"}, 64'(i), 64'(len + 1));
    chk({tag, "_cmd_ready_after"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  // mode 0: rd_ready held 1; mode 1: rd_ready 0 for 6 cycles after accept; else random
  task automatic do_read(input logic [15:0] adr, input int len, input int mode, input string tag);
    logic [31:0] expq[$];
    int T, rel, popped, oe_cnt, first_v, last_pop, g;
    for (int k = 0; k <= len; k++) expq.push_back(exp_mem[16'(adr + 16'(k))]);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_adr = adr; cmd_len = 8'(len); rd_ready = 1'b0;
    #1;
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    T = cyc;
    step();
    cmd_valid = 1'b0;
    popped = 0; oe_cnt = 0; first_v = -1; last_pop = -1; g = 0;
    while ((popped <= len || busy) && g < 300) begin
      rel = cyc - T;
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (rel > 6);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (mem_oe) oe_cnt++;
      if (rd_valid && first_v < 0) first_v = rel;
      if (rd_valid && rd_ready) begin
        if (popped <= len) chk({tag, "_rd_data"}, 64'(rd_data), 64'(expq[popped]));
        else               chk({tag, "_extra_beat"}, 64'd1, 64'd0);
        popped++;
        last_pop = rel;
      end
      if (mode == 1 && rel == 6) chk({tag, "_oe_before_ready"}, 64'(oe_cnt), 64'd2);
      step();
      g++;
    end
    rd_ready = 1'b0;
    #1;
    chk({tag, "_beats"}, 64'(popped), 64'(len + 1));
    chk({tag, "_oe_pulses"}, 64'(oe_cnt), 64'(len + 1));
    chk({tag, "_first_valid"}, 64'(first_v), 64'd3);
    if (mode == 0) chk({tag, "_last_pop"}, 64'(last_pop), 64'(3 + len));
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    chk({tag, "_rd_valid_after"}, 64'(rd_valid), 64'd0);
    chk({tag, "_cmd_ready_after"}, 64'(cmd_ready), 64'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    chk({tag, "_wd_ready"}, 64'(wd_ready), 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_mem_oe"}, 64'(mem_oe), 64'd0);
    chk({tag, "_mem_adr"}, 64'(mem_adr), 64'd0);
    chk({tag, "_mem_in"}, 64'(mem_in), 64'd0);
    chk({tag, "_rd_data"}, 64'(rd_data), 64'd0);
  endtask

  initial begin
    logic [15:0] a;
    int          l;
    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_adr = '0; cmd_len = '0;
    wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_idle_outputs("reset");
    rst = 1'b0;
    step();

    do_write(16'h0010, 3, 32'hFFFF_FFFF, 1'b0, "wr_basic");
    do_read (16'h0010, 3, 0, "rd_full_rate");
    do_read (16'h0010, 3, 1, "rd_backpressure");

    do_write(16'hFFFF, 1, 32'hFFFF_FFFF, 1'b0, "wr_wrap");
    do_read (16'hFFFF, 1, 0, "rd_wrap");

    do_write(16'h0100, 2, 32'hFFFF_FFF9, 1'b0, "wr_gaps");
    do_read (16'h0100, 2, 2, "rd_gaps");

    do_write(16'h0200, 0, 32'hFFFF_FFFF, 1'b0, "wr_len0");
    do_read (16'h0200, 0, 0, "rd_len0");

    // Reset mid-read with one word sitting in the FIFO
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_adr = 16'h0010; cmd_len = 8'd3; rd_ready = 1'b0;
    #1;
    chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0;
    step();
    step();
    #1;
    chk("rst_mid_fifo_word", 64'(rd_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    outst = 0;
    #1;
    chk_idle_outputs("rst_mid");
    do_read(16'h0010, 3, 0, "rd_after_rst");

    for (int r = 0; r < 8; r++) begin
      a = (r % 3 == 0) ? 16'(16'hFFFA + 16'($urandom_range(0, 5))) : 16'($urandom);
      l = $urandom_range(0, 7);
      do_write(a, l, 32'hFFFF_FFFF, 1'b1, "rnd_wr");
      do_read (a, l, 2, "rnd_rd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sram_burst_ctrl.md
Name: sram_burst_ctrl

Overview:
- Initiator-side controller that drives the team's single-port synchronous SRAM (clk, in, out, adr, WE, OE; one-cycle registered read) on behalf of a client.
- Accepts burst read/write commands over a valid/ready handshake, streams write data in and read data out.
- Read return is fully backpressurable.
- Sits between bus/DMA logic and the SRAM instance; sustains one beat per cycle when neither side stalls.

Parameters:
- ADR, 16: SRAM address width; addresses wrap modulo 2^ADR.
- BITS, 32: data word width.
- LEN, 8: burst-length field width; burst beats = cmd_len+1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller accepts command (IDLE only).
- cmd_wr  in  1  1=write burst, 0=read burst.
- cmd_adr  in  ADR  burst start address.
- cmd_len  in  LEN  beats minus one.
- wd_valid  in  1  write data beat offered.
- wd_ready  out  1  write beat accepted.
- wd_data  in  BITS  write data.
- rd_valid  out  1  read data beat available.
- rd_ready  in  1  client takes read beat.
- rd_data  out  BITS  read data.
- busy  out  1  state != IDLE.
- mem_adr  out  ADR  to SRAM adr.
- mem_in  out  BITS  to SRAM in.
- mem_we  out  1  to SRAM WE.
- mem_oe  out  1  to SRAM OE.
- mem_out  in  BITS  from SRAM out (valid the cycle after mem_oe).

Behaviour:
- States: IDLE, WRITE, READ, DRAIN.
- Registers: cur_adr (ADR), beats_left (LEN), oe_q, 2-entry read FIFO (count 0..2).
- Reset (rst=1 at posedge, any state incl. mid-burst):
  - state IDLE; cur_adr=0, beats_left=0, oe_q=0, FIFO count=0.
  - Next cycle: cmd_ready=1, busy=0, rd_valid=0, wd_ready=0, mem_we=0, mem_oe=0, mem_adr=0, mem_in=0, rd_data=0.
  - Abandoned bursts are not resumed; SRAM writes already issued stand.
- mem_adr = cur_adr at all times.
- mem_in = wd_data in WRITE, else 0.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: load cur_adr=cmd_adr, beats_left=cmd_len; go to WRITE or READ per cmd_wr.
- WRITE:
  - wd_ready=1; mem_we = wd_valid (combinational).
  - Per accepted beat: cur_adr+1 (wraps 2^ADR-1 -> 0); beats_left-1.
  - On the beat accepted with beats_left==0: go to IDLE. cmd_ready=1 the following cycle.
  - Gaps in wd_valid insert idle cycles; no beats are dropped.
- READ:
  - issue = (count + oe_q - pop) <= 1, where pop = rd_valid & rd_ready.
  - mem_oe = issue. Per issue: cur_adr+1 (with wrap), beats_left-1.
  - On the issue with beats_left==0: go to DRAIN.
- Read pipeline and DRAIN:
  - oe_q <= mem_oe each cycle.
  - When oe_q=1, mem_out is pushed into the FIFO at the end of that cycle.
  - rd_valid = count!=0; rd_data = FIFO head.
  - Simultaneous push and pop keeps count unchanged.
  - DRAIN: no issue; go to IDLE when count==0, oe_q==0 and no push is pending.
  - Never IDLE with data outstanding.
- Latency:
  - Command accepted in cycle T -> first mem_oe in T+1 -> first rd_valid in T+3.
  - Full rate thereafter when rd_ready=1.
- Backpressure:
  - With rd_ready=0, at most 2 words are outstanding (FIFO + in flight).
  - FIFO never overflows; data order is preserved.
- mem_we and mem_oe are never both 1.
- cmd_len=0 gives exactly one beat.

Test Plan:
- Write burst cmd_adr=0x0010, cmd_len=3, wd_data A0..A3 with wd_valid held 1 -> mem_we=1 for 4 consecutive cycles, mem_adr 0x10..0x13 with matching mem_in; cmd_ready=1 the cycle after the 4th beat.
- Read back 0x0010, len 3, rd_ready=1, command accepted cycle T -> rd_valid cycles T+3..T+6 with A0,A1,A2,A3; busy=0 afterwards.
- Same read with rd_ready=0 for first 6 cycles after acceptance -> exactly 2 mem_oe pulses then stall; after rd_ready=1, data A0..A3 in order with no loss or duplication.
- Write cmd_adr=0xFFFF, len 1 -> mem_adr 0xFFFF then 0x0000; read back returns both words.
- Write len 2 with wd_valid pattern 1,0,0,1,1 -> mem_we only on valid cycles, addresses consecutive, IDLE after 3rd beat.
- Assert rst during a read burst with 1 word in FIFO -> next cycle rd_valid=0, mem_oe=0, cmd_ready=1, busy=0; a new read returns correct data.
